rv32_mem_port_arbiter: RTL and testbench
========================================

// Module: rv32_mem_port_arbiter
// PURPOSE
//  Shares one synchronous memory port (1-cycle read latency) between instruction fetch (IF) and
//  load/store (LS). LS has priority; a streak counter guarantees IF a grant after MAX_LS_STREAK
//  back-to-back LS grants. Routes each response to its owner, drops fetch responses on flush.
//  Sits between rv32_fetch/LSU and the unified memory; a missing if_gnt_o drives stall_f upstream.
// PARAMETERS
//  MAX_LS_STREAK  4   consecutive LS grants allowed while IF waits (1..15)
// PORTS
//  clk_i         in   1   clock
//  rst_n_i       in   1   reset, asynchronous, active-low
//  if_req_i      in   1   fetch request
//  if_addr_i     in   32  fetch address (word aligned)
//  if_flush_i    in   1   discard outstanding/returning fetch response
//  if_gnt_o      out  1   fetch request accepted this cycle
//  if_rvalid_o   out  1   fetch data valid
//  if_rdata_o    out  32  fetch data
//  ls_req_i      in   1   load/store request
//  ls_we_i       in   1   1 = store
//  ls_be_i       in   4   byte enables
//  ls_addr_i     in   32  data address
//  ls_wdata_i    in   32  store data
//  ls_gnt_o      out  1   LS request accepted this cycle
//  ls_rvalid_o   out  1   load data valid / store ack
//  ls_rdata_o    out  32  load data
//  mem_req_o     out  1   memory request
//  mem_we_o      out  1   memory write enable (0 for IF)
//  mem_be_o      out  4   byte enables (4'hF for IF)
//  mem_addr_o    out  32  memory address
//  mem_wdata_o   out  32  memory write data (0 for IF)
//  mem_gnt_i     in   1   memory accepts request this cycle
//  mem_rvalid_i  in   1   response valid, exactly 1 cycle after accepted request
//  mem_rdata_i   in   32  response data
//  protocol_err_o out 1   sticky: mem_rvalid_i with no outstanding request
// BEHAVIOUR
//  - Selection (comb): sel_if = if_req_i & (!ls_req_i | streak_q==MAX_LS_STREAK); else LS if ls_req_i.
//  - mem_req_o = if_req_i|ls_req_i; mem_* muxed from winner; x_gnt_o = winner & mem_gnt_i.
//  - Accept = mem_req_o & mem_gnt_i. Owner reg owner_q {NONE,IF,LS} <= winner on accept, else NONE.
//  - streak_q: +1 on LS accept while if_req_i high (saturate at MAX); 0 on IF accept or !if_req_i.
//  - kill_q <= IF accept & if_flush_i (request issued in flush cycle is dropped on return).
//  - if_rvalid_o = mem_rvalid_i & owner_q==IF & !kill_q & !if_flush_i (same-cycle flush drops).
//  - ls_rvalid_o = mem_rvalid_i & owner_q==LS, also for stores; rdata ports pass mem_rdata_i.
//  - mem_rvalid_i & owner_q==NONE: no rvalid out, protocol_err_o <= 1 until reset.
//  - Back-to-back: new accept allowed in cycle a response returns (one outstanding, pipelined).
//  - mem_gnt_i low: no accept, owner_q<=NONE, streak unchanged, requesters hold request stable.
//  - Reset: owner_q=NONE, streak_q=0, kill_q=0, protocol_err_o=0; all grants/rvalids 0.
//  - Reset mid-transaction: pending response discarded; rvalid after reset flags protocol_err_o.
// STRUCTURE
//  - rv32_mem_pkg: typedef enum logic [1:0] {OWN_NONE,OWN_IF,OWN_LS} mem_owner_e; BE_FULL=4'hF.
//  - Single module; selection + streak counter may be split into rv32_arb_prio sub-module.
// TESTING
//  - Reset, if_req_i=1 @0x0, mem_gnt_i=1 -> if_gnt_o=1, next cycle if_rvalid_o=1, rdata=mem data.
//  - if_req+ls_req (load @0x100) same cycle -> ls_gnt_o=1, if_gnt_o=0; ls_rvalid_o next cycle.
//  - Both requests held, MAX=4 -> LS,LS,LS,LS,IF,LS... grant pattern; streak resets after IF.
//  - IF accepted cycle N, if_flush_i at N or N+1 -> if_rvalid_o stays 0 at N+1.
//  - Store we=1 be=4'b0011 -> mem_we_o=1, mem_be_o=0011, ls_rvalid_o ack; mem_gnt_i=0 -> no gnt.
//  - mem_rvalid_i with no request -> protocol_err_o=1 sticky; cleared only by rst_n_i.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared types for the IF/LS memory port arbiter.
package rv32_mem_pkg;

  // Owner of the single outstanding memory access.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } mem_owner_e;

  // Instruction fetches always read a full word.
  localparam logic [3:0] BE_FULL = 4'hF;

  // One request as presented to the memory port.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rv32_arb_prio.sv
// LS-priority selection with an anti-starvation streak counter for IF.
module rv32_arb_prio
  import rv32_mem_pkg::*;
#(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic if_req,
  input  logic ls_req,
  input  logic mem_gnt,
  output logic sel_if,
  output logic sel_ls
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

  logic [3:0] streak_q;
  logic       accept;

  // IF only wins against LS once LS has used up its streak allowance.
  always_comb begin
    sel_if = if_req & (~ls_req | (streak_q == STREAK_MAX));
    sel_ls = ls_req & ~sel_if;
    accept = (if_req | ls_req) & mem_gnt;
  end

  // Count LS grants taken while IF waits; clears once IF is served or stops asking.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                         streak_q <= '0;
    else if (!if_req || (accept && sel_if)) streak_q <= '0;
    else if (accept && sel_ls && streak_q != STREAK_MAX)
                                          streak_q <= streak_q + 4'd1;
  end

endmodule

// File: rtl/rv32_mem_port_arbiter.sv
// Shares one 1-cycle-latency memory port between instruction fetch and load/store.
module rv32_mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        protocol_err_o
);

  logic       sel_if, sel_ls, accept;
  mem_req_t   win;
  mem_owner_e owner_q;
  logic       kill_q;

  rv32_arb_prio #(.MAX_LS_STREAK(MAX_LS_STREAK)) u_prio (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .if_req  (if_req_i),
    .ls_req  (ls_req_i),
    .mem_gnt (mem_gnt_i),
    .sel_if  (sel_if),
    .sel_ls  (sel_ls)
  );

  // Mux the winning requester onto the memory port; fetches are full-word reads.
  always_comb begin
    if (sel_if) win = '{we: 1'b0, be: BE_FULL, addr: if_addr_i, wdata: 32'h0};
    else        win = '{we: ls_we_i, be: ls_be_i, addr: ls_addr_i, wdata: ls_wdata_i};
    accept      = mem_req_o & mem_gnt_i;
  end

  assign mem_req_o   = if_req_i | ls_req_i;
  assign mem_we_o    = win.we;
  assign mem_be_o    = win.be;
  assign mem_addr_o  = win.addr;
  assign mem_wdata_o = win.wdata;
  assign if_gnt_o    = sel_if & mem_gnt_i;
  assign ls_gnt_o    = sel_ls & mem_gnt_i;

  // Track who owns the response due next cycle; a fetch issued during flush is marked dead.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_q <= OWN_NONE;
      kill_q  <= 1'b0;
    end else begin
      owner_q <= !accept ? OWN_NONE : (sel_if ? OWN_IF : OWN_LS);
      kill_q  <= accept & sel_if & if_flush_i;
    end
  end

  // A response nobody is waiting for (including one orphaned by reset) is a sticky error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                   protocol_err_o <= 1'b0;
    else if (mem_rvalid_i && owner_q == OWN_NONE)   protocol_err_o <= 1'b1;
  end

  assign if_rvalid_o = mem_rvalid_i & (owner_q == OWN_IF) & ~kill_q & ~if_flush_i;
  assign ls_rvalid_o = mem_rvalid_i & (owner_q == OWN_LS);
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_rv32_mem_port_arbiter.sv
// Directed bench with a response scoreboard for rv32_mem_port_arbiter.
module tb_rv32_mem_port_arbiter;

  localparam logic [31:0] KEY = 32'h5A3C_96E1;
  localparam int K_IF = 0, K_LS = 1, K_DROP = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic        if_req_i = 1'b0, if_flush_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i = 1'b0, ls_we_i = 1'b0;
  logic [3:0]  ls_be_i = 4'hF;
  logic [31:0] ls_addr_i = '0, ls_wdata_i = '0;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b1;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        protocol_err_o;

  logic        mdl_rv = 1'b0, inj_rv = 1'b0;
  logic [31:0] mdl_rd = '0;
  exp_t        sb[$];
  int          vec = 0, errs = 0;

  rv32_mem_port_arbiter #(.MAX_LS_STREAK(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: answers every accepted request one cycle later with addr ^ KEY.
  always @(posedge clk_i) begin
    mdl_rv <= mem_req_o & mem_gnt_i;
    mdl_rd <= mem_addr_o ^ KEY;
  end
  assign mem_rvalid_i = mdl_rv | inj_rv;
  assign mem_rdata_i  = mdl_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: check responses due now and the grants, queue expected responses, advance.
  task automatic step(input logic e_if, input logic e_ls);
    exp_t        e;
    logic        x_if, x_ls;
    logic [31:0] d;
    #1;
    x_if = 1'b0; x_ls = 1'b0; d = '0;
    if (sb.size() > 0) begin
      e    = sb.pop_front();
      x_if = (e.kind == K_IF) && !if_flush_i;
      x_ls = (e.kind == K_LS);
      d    = e.data;
    end
    chk("if_rvalid", {31'b0, if_rvalid_o}, {31'b0, x_if});
    chk("ls_rvalid", {31'b0, ls_rvalid_o}, {31'b0, x_ls});
    if (x_if) chk("if_rdata", if_rdata_o, d);
    if (x_ls) chk("ls_rdata", ls_rdata_o, d);
    chk("if_gnt", {31'b0, if_gnt_o}, {31'b0, e_if});
    chk("ls_gnt", {31'b0, ls_gnt_o}, {31'b0, e_ls});
    if (e_if) sb.push_back('{if_flush_i ? K_DROP : K_IF, if_addr_i ^ KEY});
    if (e_ls) sb.push_back('{K_LS, ls_addr_i ^ KEY});
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    logic pat [6];
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    #2;
    chk("rst_if_gnt", {31'b0, if_gnt_o}, 32'd0);
    chk("rst_rvalid", {30'b0, if_rvalid_o, ls_rvalid_o}, 32'd0);
    chk("rst_perr", {31'b0, protocol_err_o}, 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_n_i = 1'b1;

    // Plain fetch at 0x0
    if_req_i = 1'b1; if_addr_i = 32'h0;
    #1;
    chk("if_mem_we", {31'b0, mem_we_o}, 32'd0);
    chk("if_mem_be", {28'b0, mem_be_o}, 32'hF);
    chk("if_mem_wdata", mem_wdata_o, 32'h0);
    step(1'b1, 1'b0);
    if_req_i = 1'b0;
    step(1'b0, 1'b0);

    // Collision: LS load wins
    if_req_i = 1'b1; if_addr_i = 32'h40; ls_req_i = 1'b1; ls_addr_i = 32'h100;
    step(1'b0, 1'b1);
    if_req_i = 1'b0; ls_req_i = 1'b0;
    step(1'b0, 1'b0);

    // Both held: LS x4, IF, LS
    if_req_i = 1'b1; if_addr_i = 32'h80; ls_req_i = 1'b1; ls_addr_i = 32'h204;
    for (int i = 0; i < 6; i++) step(pat[i], !pat[i]);
    if_req_i = 1'b0; ls_req_i = 1'b0;
    step(1'b0, 1'b0);

    // Flush in the accept cycle
    if_req_i = 1'b1; if_addr_i = 32'hC0; if_flush_i = 1'b1;
    step(1'b1, 1'b0);
    if_req_i = 1'b0; if_flush_i = 1'b0;
    step(1'b0, 1'b0);
    // Flush in the response cycle
    if_req_i = 1'b1; if_addr_i = 32'hC4;
    step(1'b1, 1'b0);
    if_req_i = 1'b0; if_flush_i = 1'b1;
    step(1'b0, 1'b0);
    if_flush_i = 1'b0;

    // Store with partial byte enables, then memory stalls
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'b0011;
    ls_addr_i = 32'h300; ls_wdata_i = 32'hCAFE_F00D;
    #1;
    chk("st_mem_we", {31'b0, mem_we_o}, 32'd1);
    chk("st_mem_be", {28'b0, mem_be_o}, 32'h3);
    chk("st_mem_wdata", mem_wdata_o, 32'hCAFE_F00D);
    chk("st_mem_addr", mem_addr_o, 32'h300);
    step(1'b0, 1'b1);
    mem_gnt_i = 1'b0; ls_addr_i = 32'h304;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    mem_gnt_i = 1'b1;
    step(1'b0, 1'b1);
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = 4'hF;
    step(1'b0, 1'b0);
    chk("perr_clean", {31'b0, protocol_err_o}, 32'd0);

    // Unsolicited response -> sticky protocol error
    inj_rv = 1'b1;
    step(1'b0, 1'b0);
    inj_rv = 1'b0;
    chk("perr_set", {31'b0, protocol_err_o}, 32'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("perr_sticky", {31'b0, protocol_err_o}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    chk("perr_cleared", {31'b0, protocol_err_o}, 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Reset while a fetch response is pending: dropped, then flagged
    if_req_i = 1'b1; if_addr_i = 32'h1F0;
    step(1'b1, 1'b0);
    sb.delete();
    if_req_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    chk("rstmid_if_rvalid", {31'b0, if_rvalid_o}, 32'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rstmid_perr", {31'b0, protocol_err_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
